pe_ctrl_multipass: RTL and testbench
====================================

// Module: pe_ctrl_multipass
// PURPOSE
//  Parametrised PE controller: sequences LOAD -> CAL -> (repeat per pass) -> DRAIN for one PE.
//  Counts MAC cycles internally, accumulates psums over several passes and drains them in beats.
//  Sits between the PE-cluster top-level and a PE's MAC/scratchpad datapath.
// PARAMETERS
//  CNT_W        8  width of the MAC-cycle counter and cfg_mac_len
//  PASS_W       4  width of the pass counter and cfg_pass_num
//  DRAIN_BEATS  4  psum beats emitted in DRAIN (>=1)
// PORTS
//  clock          in   1       clock
//  reset          in   1       reset, synchronous, active-high
//  cfg_mac_len    in   CNT_W   MAC cycles per pass; 0 is treated as 1
//  cfg_pass_num   in   PASS_W  passes before drain; 0 is treated as 1
//  top_do_load_en in   1       start request; sampled in IDLE only
//  top_write_fin  in   1       scratchpad load complete; sampled in LOAD only
//  abort          in   1       synchronous abort; returns to IDLE next cycle
//  drain_ready    in   1       downstream accepts a psum beat
//  load_en        out  1       high throughout LOAD
//  mac_en         out  1       high throughout CAL
//  psum_clr       out  1       1-cycle pulse on the first CAL cycle of pass 0
//  mac_idx        out  CNT_W   current MAC index within the pass (0..len-1); 0 outside CAL
//  pass_idx       out  PASS_W  current pass index
//  drain_valid    out  1       psum beat valid (DRAIN state)
//  drain_idx      out  $clog2(DRAIN_BEATS)+1  beat index during DRAIN
//  top_cal_fin    out  1       1-cycle pulse after the last drain beat is accepted
//  busy           out  1       state != IDLE
// BEHAVIOUR
//  - State encoding: IDLE=0, LOAD=1, CAL=2, DRAIN=3. Reset: state IDLE, all counters 0, every output 0.
//  - IDLE: on top_do_load_en, latch cfg_mac_len/cfg_pass_num (zero->1), clear pass_idx, go LOAD.
//    The config ports are ignored in every other state.
//  - LOAD: load_en=1. On top_write_fin go CAL with mac_idx=0 (one-cycle latency).
//  - CAL: mac_en=1 and mac_idx increments each cycle. On the cycle where mac_idx==len-1:
//    - if pass_idx < passes-1: pass_idx++ and go LOAD (reload for the next pass; psums retained).
//    - else go DRAIN with drain_idx=0.
//  - CAL length is exactly len cycles per pass; psum_clr is high only when pass_idx==0 and mac_idx==0.
//  - DRAIN: drain_valid=1. Beat transfers when drain_valid&drain_ready; drain_idx increments.
//    - Hold drain_valid and drain_idx stable while drain_ready=0.
//    - On transfer of beat DRAIN_BEATS-1: go IDLE; top_cal_fin pulses on the first IDLE cycle.
//  - Abort has priority over every transition: next state IDLE, counters cleared, no top_cal_fin.
//    Abort in IDLE is a no-op. Reset mid-operation behaves the same as abort.
//  - top_do_load_en outside IDLE is ignored; no queueing.
//  - top_do_load_en in the same cycle as top_cal_fin is accepted (back-to-back jobs).
//  - Counter widths: mac_idx wraps never (bounded by len <= 2^CNT_W-1); len=2^CNT_W is not expressible.
// CONFIGURATION
//  PE_CTRL_PERF_EN defined: adds outputs perf_cal_cycles[31:0] and perf_stall_cycles[31:0].
//    - perf_cal_cycles counts cycles with mac_en=1.
//    - perf_stall_cycles counts DRAIN cycles with drain_ready=0.
//    - Both are saturating, cleared by reset only (not by abort).
//  Not defined: the perf ports and counters are absent; all other behaviour is identical.
// TESTING
//  1. len=3, passes=1, drain_ready=1 -> LOAD; then mac_en for exactly 3 cycles with mac_idx 0,1,2;
//     psum_clr on idx 0; 4 drain beats; top_cal_fin pulses once; 0 cycles of stall.
//  2. len=2, passes=3 -> three LOAD/CAL rounds with pass_idx 0,1,2; psum_clr only in round 0;
//     mac_en total 6 cycles.
//  3. cfg_mac_len=0, cfg_pass_num=0 -> behaves as len=1, passes=1 (single mac_en cycle).
//  4. DRAIN with drain_ready toggling 1,0,0,1,1,0,1 -> drain_idx stable while stalled;
//     4 transfers; top_cal_fin after the 4th transfer; with PE_CTRL_PERF_EN, perf_stall_cycles=3.
//  5. Abort during CAL (mac_idx=1) -> IDLE next cycle; outputs 0; no top_cal_fin;
//     a new job then runs cleanly.
//  6. Config changed during CAL -> no effect. top_do_load_en asserted with top_cal_fin
//     -> next job enters LOAD the following cycle.

Source files
------------

// File: rtl/pe_ctrl_multipass.sv
// PE controller: LOAD -> CAL (repeated per pass) -> DRAIN sequencer for one PE.
// Optional perf counters are compiled in with PE_CTRL_PERF_EN.
module pe_ctrl_multipass #(
  parameter int CNT_W       = 8,
  parameter int PASS_W      = 4,
  parameter int DRAIN_BEATS = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [CNT_W-1:0]               cfg_mac_len,
  input  logic [PASS_W-1:0]              cfg_pass_num,
  input  logic                           top_do_load_en,
  input  logic                           top_write_fin,
  input  logic                           abort,
  input  logic                           drain_ready,
  output logic                           load_en,
  output logic                           mac_en,
  output logic                           psum_clr,
  output logic [CNT_W-1:0]               mac_idx,
  output logic [PASS_W-1:0]              pass_idx,
  output logic                           drain_valid,
  output logic [$clog2(DRAIN_BEATS):0]   drain_idx,
  output logic                           top_cal_fin,
  output logic                           busy
`ifdef PE_CTRL_PERF_EN
  ,
  output logic [31:0]                    perf_cal_cycles,
  output logic [31:0]                    perf_stall_cycles
`endif
);

  localparam int DW = $clog2(DRAIN_BEATS) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CAL   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [PASS_W-1:0] passes_q, passes_d;
  logic [CNT_W-1:0]  mac_idx_q, mac_idx_d;
  logic [PASS_W-1:0] pass_idx_q, pass_idx_d;
  logic [DW-1:0]     drain_idx_q, drain_idx_d;
  logic              fin_q, fin_d;
  logic              load_en_q, mac_en_q, psum_clr_q, drain_valid_q, busy_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    passes_d    = passes_q;
    mac_idx_d   = mac_idx_q;
    pass_idx_d  = pass_idx_q;
    drain_idx_d = drain_idx_q;
    fin_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (top_do_load_en) begin
          len_d      = (cfg_mac_len == '0) ? CNT_W'(1) : cfg_mac_len;
          passes_d   = (cfg_pass_num == '0) ? PASS_W'(1) : cfg_pass_num;
          pass_idx_d = '0;
          mac_idx_d  = '0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (top_write_fin) begin
          mac_idx_d = '0;
          state_d   = CAL;
        end
      end
      CAL: begin
        if (mac_idx_q == len_q - CNT_W'(1)) begin
          mac_idx_d = '0;
          if (pass_idx_q < passes_q - PASS_W'(1)) begin
            pass_idx_d = pass_idx_q + PASS_W'(1);
            state_d    = LOAD;
          end else begin
            drain_idx_d = '0;
            state_d     = DRAIN;
          end
        end else begin
          mac_idx_d = mac_idx_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (drain_ready) begin
          if (drain_idx_q == DW'(DRAIN_BEATS - 1)) begin
            drain_idx_d = '0;
            pass_idx_d  = '0;
            fin_d       = 1'b1;
            state_d     = IDLE;
          end else begin
            drain_idx_d = drain_idx_q + DW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // abort wins over every transition and suppresses the completion pulse
    if (abort) begin
      state_d     = IDLE;
      mac_idx_d   = '0;
      pass_idx_d  = '0;
      drain_idx_d = '0;
      fin_d       = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      len_q         <= '0;
      passes_q      <= '0;
      mac_idx_q     <= '0;
      pass_idx_q    <= '0;
      drain_idx_q   <= '0;
      fin_q         <= 1'b0;
      load_en_q     <= 1'b0;
      mac_en_q      <= 1'b0;
      psum_clr_q    <= 1'b0;
      drain_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      passes_q      <= passes_d;
      mac_idx_q     <= mac_idx_d;
      pass_idx_q    <= pass_idx_d;
      drain_idx_q   <= drain_idx_d;
      fin_q         <= fin_d;
      load_en_q     <= (state_d == LOAD);
      mac_en_q      <= (state_d == CAL);
      psum_clr_q    <= (state_d == CAL) && (pass_idx_d == '0) && (mac_idx_d == '0);
      drain_valid_q <= (state_d == DRAIN);
      busy_q        <= (state_d != IDLE);
    end
  end

  assign load_en     = load_en_q;
  assign mac_en      = mac_en_q;
  assign psum_clr    = psum_clr_q;
  assign mac_idx     = mac_idx_q;
  assign pass_idx    = pass_idx_q;
  assign drain_valid = drain_valid_q;
  assign drain_idx   = drain_idx_q;
  assign top_cal_fin = fin_q;
  assign busy        = busy_q;

`ifdef PE_CTRL_PERF_EN
  // saturating counters; survive abort, cleared only by reset
  logic [31:0] perf_cal_q, perf_cal_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_cal_d   = perf_cal_q;
    perf_stall_d = perf_stall_q;
    if (mac_en_q && !(&perf_cal_q))
      perf_cal_d = perf_cal_q + 32'd1;
    if ((state_q == DRAIN) && !drain_ready && !(&perf_stall_q))
      perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_cal_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_cal_q   <= perf_cal_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_cal_cycles   = perf_cal_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_pe_ctrl_multipass.sv
// Scoreboard bench for pe_ctrl_multipass: driver pushes expected MAC/drain/fin
// events, a negedge monitor pops and compares them as the DUT emits them.
module tb_pe_ctrl_multipass;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] cfg_mac_len;
  logic [3:0] cfg_pass_num;
  logic       top_do_load_en, top_write_fin, abort, drain_ready;
  logic       load_en, mac_en, psum_clr, drain_valid, top_cal_fin, busy;
  logic [7:0] mac_idx;
  logic [3:0] pass_idx;
  logic [2:0] drain_idx;
`ifdef PE_CTRL_PERF_EN
  logic [31:0] perf_cal_cycles, perf_stall_cycles;
  logic [31:0] cal0, stall0;
`endif

  pe_ctrl_multipass #(.CNT_W(8), .PASS_W(4), .DRAIN_BEATS(4)) dut (
    .clock(clock), .reset(reset),
    .cfg_mac_len(cfg_mac_len), .cfg_pass_num(cfg_pass_num),
    .top_do_load_en(top_do_load_en), .top_write_fin(top_write_fin),
    .abort(abort), .drain_ready(drain_ready),
    .load_en(load_en), .mac_en(mac_en), .psum_clr(psum_clr),
    .mac_idx(mac_idx), .pass_idx(pass_idx),
    .drain_valid(drain_valid), .drain_idx(drain_idx),
    .top_cal_fin(top_cal_fin), .busy(busy)
`ifdef PE_CTRL_PERF_EN
    , .perf_cal_cycles(perf_cal_cycles), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] pass;
    logic [7:0] idx;
    logic       clr;
  } mac_exp_t;

  mac_exp_t   mac_q[$];
  logic [2:0] drain_q[$];
  int         fin_q[$];
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic       prev_stall = 1'b0;
  logic [2:0] prev_didx  = '0;

  always @(negedge clock) begin
    if (!reset) begin
      if (mac_en) begin
        if (mac_q.size() == 0) chk("mac_unexpected", 32'd1, 32'd0);
        else begin
          mac_exp_t e;
          e = mac_q.pop_front();
          chk("pass_idx", {28'd0, pass_idx}, {28'd0, e.pass});
          chk("mac_idx", {24'd0, mac_idx}, {24'd0, e.idx});
          chk("psum_clr", {31'd0, psum_clr}, {31'd0, e.clr});
        end
      end else begin
        chk("psum_clr_outside_cal", {31'd0, psum_clr}, 32'd0);
        chk("mac_idx_outside_cal", {24'd0, mac_idx}, 32'd0);
      end
      if (prev_stall) begin
        chk("stall_valid_hold", {31'd0, drain_valid}, 32'd1);
        chk("stall_idx_hold", {29'd0, drain_idx}, {29'd0, prev_didx});
      end
      if (drain_valid && drain_ready) begin
        if (drain_q.size() == 0) chk("drain_unexpected", 32'd1, 32'd0);
        else chk("drain_idx", {29'd0, drain_idx}, {29'd0, drain_q.pop_front()});
      end
      if (top_cal_fin) begin
        if (fin_q.size() == 0) chk("fin_unexpected", 32'd1, 32'd0);
        else chk("fin_pulse", 32'd1, 32'(fin_q.pop_front()));
      end
      prev_stall = drain_valid && !drain_ready;
      prev_didx  = drain_idx;
    end
  end

  // ---------------- driver ----------------
  task automatic cyc();
    @(posedge clock); #1;
  endtask

  // Issues a start in the current cycle and queues the full expected job.
  task automatic start_job(input logic [7:0] l, input logic [3:0] p);
    int el, ep;
    el = (l == 0) ? 1 : int'(l);
    ep = (p == 0) ? 1 : int'(p);
    for (int pp = 0; pp < ep; pp++)
      for (int i = 0; i < el; i++)
        mac_q.push_back('{pass: 4'(pp), idx: 8'(i), clr: (pp == 0 && i == 0)});
    for (int d = 0; d < 4; d++) drain_q.push_back(3'(d));
    fin_q.push_back(1);
    cfg_mac_len    = l;
    cfg_pass_num   = p;
    top_do_load_en = 1'b1;
    cyc();
    top_do_load_en = 1'b0;
  endtask

  task automatic run_passes(input int el, input int ep, input bit scramble);
    for (int pp = 0; pp < ep; pp++) begin
      chk("load_en", {31'd0, load_en}, 32'd1);
      top_write_fin = 1'b1;
      cyc();
      top_write_fin = 1'b0;
      chk("cal_entry", {31'd0, mac_en}, 32'd1);
      if (scramble) begin
        cfg_mac_len  = 8'd9;
        cfg_pass_num = 4'd7;
      end
      for (int i = 0; i < el; i++) cyc();
    end
    chk("drain_entry", {31'd0, drain_valid}, 32'd1);
  endtask

  task automatic drain(input logic [15:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      drain_ready = pat[i];
      cyc();
    end
    drain_ready = 1'b0;
    chk("fin_after_drain", {31'd0, top_cal_fin}, 32'd1);
    chk("busy_after_drain", {31'd0, busy}, 32'd0);
  endtask

  task automatic queues_empty(input string tag);
    @(negedge clock); #1;
    chk({tag, "_mac_left"}, 32'(mac_q.size()), 32'd0);
    chk({tag, "_drain_left"}, 32'(drain_q.size()), 32'd0);
    chk({tag, "_fin_left"}, 32'(fin_q.size()), 32'd0);
  endtask

  task automatic perf_mark();
`ifdef PE_CTRL_PERF_EN
    cal0   = perf_cal_cycles;
    stall0 = perf_stall_cycles;
`endif
  endtask

  task automatic perf_check(input int cal, input int stall);
`ifdef PE_CTRL_PERF_EN
    chk("perf_cal_delta", perf_cal_cycles - cal0, 32'(cal));
    chk("perf_stall_delta", perf_stall_cycles - stall0, 32'(stall));
`endif
  endtask

  initial begin
    reset = 1'b1; cfg_mac_len = 8'd0; cfg_pass_num = 4'd0;
    top_do_load_en = 1'b0; top_write_fin = 1'b0; abort = 1'b0; drain_ready = 1'b0;
    repeat (3) cyc();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_load_en", {31'd0, load_en}, 32'd0);
    chk("rst_mac_en", {31'd0, mac_en}, 32'd0);
    chk("rst_drain_valid", {31'd0, drain_valid}, 32'd0);
    chk("rst_fin", {31'd0, top_cal_fin}, 32'd0);
    chk("rst_idx", {16'd0, mac_idx, pass_idx, 1'b0, drain_idx}, 32'd0);
`ifdef PE_CTRL_PERF_EN
    chk("rst_perf", perf_cal_cycles | perf_stall_cycles, 32'd0);
`endif
    reset = 1'b0;
    cyc();

    // 1: len=3, one pass, free-flowing drain
    perf_mark();
    start_job(8'd3, 4'd1);
    run_passes(3, 1, 1'b0);
    drain(16'hF, 4);
    perf_check(3, 0);
    queues_empty("t1");

    // 2: len=2, three passes
    perf_mark();
    start_job(8'd2, 4'd3);
    run_passes(2, 3, 1'b0);
    drain(16'hF, 4);
    perf_check(6, 0);
    queues_empty("t2");

    // 3: zero config treated as len=1, passes=1
    perf_mark();
    start_job(8'd0, 4'd0);
    run_passes(1, 1, 1'b0);
    drain(16'hF, 4);
    perf_check(1, 0);
    queues_empty("t3");

    // 4: drain backpressure 1,0,0,1,1,0,1
    perf_mark();
    start_job(8'd2, 4'd1);
    run_passes(2, 1, 1'b0);
    drain(16'b1011001, 7);
    perf_check(2, 3);
    queues_empty("t4");

    // 5: abort at mac_idx=1 of a len=4 job
    mac_q.push_back('{pass: 4'd0, idx: 8'd0, clr: 1'b1});
    mac_q.push_back('{pass: 4'd0, idx: 8'd1, clr: 1'b0});
    cfg_mac_len = 8'd4; cfg_pass_num = 4'd1; top_do_load_en = 1'b1;
    cyc();
    top_do_load_en = 1'b0; top_write_fin = 1'b1;
    cyc();
    top_write_fin = 1'b0;
    cyc();
    chk("pre_abort_idx", {24'd0, mac_idx}, 32'd1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_mac_en", {31'd0, mac_en}, 32'd0);
    chk("abort_idx", {16'd0, mac_idx, pass_idx, 1'b0, drain_idx}, 32'd0);
    repeat (3) cyc();
    chk("abort_no_fin", {31'd0, top_cal_fin}, 32'd0);
    queues_empty("t5a");
    start_job(8'd1, 4'd2);
    run_passes(1, 2, 1'b0);
    drain(16'hF, 4);
    queues_empty("t5b");

    // 6: config scrambled during CAL, then back-to-back start on top_cal_fin
    start_job(8'd3, 4'd2);
    run_passes(3, 2, 1'b1);
    drain(16'hF, 4);
    start_job(8'd2, 4'd1);
    chk("b2b_load_en", {31'd0, load_en}, 32'd1);
    run_passes(2, 1, 1'b0);
    drain(16'hF, 4);
    queues_empty("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
